// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer. It fetches the word at PC, holds it in IR,
// and loads the next PC from the PC mux when the control unit commands a write.
module pc_fetch_unit #(
  parameter int                 WIDTH    = 16,
  parameter logic [WIDTH-1:0]   RESET_PC = 16'h0000,
  parameter int                 PC_STEP  = 2
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] SelectedPC,
  input  logic             PCWrite,
  input  logic             Stall,
  output logic             IMemReq,
  output logic [WIDTH-1:0] IMemAddr,
  input  logic             IMemReady,
  input  logic [WIDTH-1:0] IMemData,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] IR,
  output logic             IRValid,
  output logic [WIDTH-1:0] PCincrement,
  output logic [WIDTH-1:0] ConcatenatedPC,
  output logic             PCAlignErr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             irvalid_q, irvalid_d;
  logic             align_err_q, align_err_d;
  logic             pc_load;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A load only happens from HOLD; a concurrent Stall blocks it.
  assign pc_load = (state_q == HOLD) && PCWrite && !Stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!Stall)   state_d = FETCH;
      FETCH:   if (IMemReady) state_d = HOLD;
      HOLD:    if (pc_load)  state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    IMemReq = (state_q == FETCH);
  end

  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    irvalid_d   = irvalid_q;
    align_err_d = 1'b0;
    // Memory responses are accepted in FETCH regardless of Stall.
    if ((state_q == FETCH) && IMemReady) begin
      ir_d      = IMemData;
      irvalid_d = 1'b1;
    end
    if (pc_load) begin
      pc_d        = {SelectedPC[WIDTH-1:1], 1'b0};
      irvalid_d   = 1'b0;
      align_err_d = SelectedPC[0];
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      irvalid_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      irvalid_q   <= irvalid_d;
      align_err_q <= align_err_d;
    end
  end

  assign PC             = pc_q;
  assign IMemAddr       = pc_q;
  assign IR             = ir_q;
  assign IRValid        = irvalid_q;
  assign PCAlignErr     = align_err_q;
  assign PCincrement    = pc_q + STEP;
  // Jump target keeps the top three bits of the next sequential PC.
  assign ConcatenatedPC = {PCincrement[WIDTH-1:WIDTH-3], ir_q[WIDTH-5:0], 1'b0};

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a fetch/load vector table plus hand-written
// sequences for stalls, wait states and asynchronous reset.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic [15:0] SelectedPC;
  logic        PCWrite;
  logic        Stall;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemReady;
  logic [15:0] IMemData;
  logic [15:0] PC;
  logic [15:0] IR;
  logic        IRValid;
  logic [15:0] PCincrement;
  logic [15:0] ConcatenatedPC;
  logic        PCAlignErr;

  int compared   = 0;
  int mismatched = 0;

  pc_fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .SelectedPC(SelectedPC), .PCWrite(PCWrite),
    .Stall(Stall), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady),
    .IMemData(IMemData), .PC(PC), .IR(IR), .IRValid(IRValid),
    .PCincrement(PCincrement), .ConcatenatedPC(ConcatenatedPC), .PCAlignErr(PCAlignErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] pc_before;
    logic [15:0] data;
    logic [15:0] exp_inc;
    logic [15:0] exp_concat;
    logic [15:0] sel;
    logic [15:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  initial begin
    //        pc_before data      inc       concat    sel       exp_pc    err
    vecs[0] = '{16'h0000, 16'h1234, 16'h0002, 16'h0468, 16'h007F, 16'h007E, 1'b1};
    vecs[1] = '{16'h007E, 16'h0ABC, 16'h0080, 16'h1578, 16'h4000, 16'h4000, 1'b0};
    vecs[2] = '{16'h4000, 16'h0ABC, 16'h4002, 16'h5578, 16'hFFFE, 16'hFFFE, 1'b0};
    vecs[3] = '{16'hFFFE, 16'hF00F, 16'h0000, 16'h001E, 16'hA5A5, 16'hA5A4, 1'b1};
    vecs[4] = '{16'hA5A4, 16'h8FFF, 16'hA5A6, 16'hBFFE, 16'hE002, 16'hE002, 1'b0};
    vecs[5] = '{16'hE002, 16'h5555, 16'hE004, 16'hEAAA, 16'h0001, 16'h0000, 1'b1};

    Reset_n    = 1'b0;
    SelectedPC = 16'h0000;
    PCWrite    = 1'b0;
    Stall      = 1'b0;
    IMemReady  = 1'b1;
    IMemData   = 16'h1234;
    #1;
    check("rst_imemreq", {15'd0, IMemReq}, 16'd0);
    check("rst_pc", PC, 16'h0000);
    check("rst_ir", IR, 16'h0000);
    check("rst_irvalid", {15'd0, IRValid}, 16'd0);
    check("rst_alignerr", {15'd0, PCAlignErr}, 16'd0);
    tick();
    tick();
    Reset_n = 1'b1;
    check("idle_imemreq", {15'd0, IMemReq}, 16'd0);
    check("idle_irvalid", {15'd0, IRValid}, 16'd0);
    tick();
    check("first_fetch_req", {15'd0, IMemReq}, 16'd1);

    for (int i = 0; i < 6; i++) begin
      check($sformatf("v%0d_req", i), {15'd0, IMemReq}, 16'd1);
      check($sformatf("v%0d_addr", i), IMemAddr, vecs[i].pc_before);
      check($sformatf("v%0d_pc", i), PC, vecs[i].pc_before);
      IMemReady = 1'b1;
      IMemData  = vecs[i].data;
      tick();
      IMemReady = 1'b0;
      check($sformatf("v%0d_ir", i), IR, vecs[i].data);
      check($sformatf("v%0d_irvalid", i), {15'd0, IRValid}, 16'd1);
      check($sformatf("v%0d_inc", i), PCincrement, vecs[i].exp_inc);
      check($sformatf("v%0d_concat", i), ConcatenatedPC, vecs[i].exp_concat);
      check($sformatf("v%0d_hold_req", i), {15'd0, IMemReq}, 16'd0);
      check($sformatf("v%0d_err_clear", i), {15'd0, PCAlignErr}, 16'd0);
      SelectedPC = vecs[i].sel;
      PCWrite    = 1'b1;
      tick();
      PCWrite = 1'b0;
      check($sformatf("v%0d_load_pc", i), PC, vecs[i].exp_pc);
      check($sformatf("v%0d_load_err", i), {15'd0, PCAlignErr}, {15'd0, vecs[i].exp_err});
      check($sformatf("v%0d_load_irvalid", i), {15'd0, IRValid}, 16'd0);
      check($sformatf("v%0d_load_req", i), {15'd0, IMemReq}, 16'd1);
      check($sformatf("v%0d_load_addr", i), IMemAddr, vecs[i].exp_pc);
    end

    // PCWrite during FETCH with memory not ready is ignored.
    SelectedPC = 16'h1230;
    PCWrite    = 1'b1;
    IMemReady  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("fetchwr%0d_pc", c), PC, 16'h0000);
      check($sformatf("fetchwr%0d_req", c), {15'd0, IMemReq}, 16'd1);
      check($sformatf("fetchwr%0d_irvalid", c), {15'd0, IRValid}, 16'd0);
      check($sformatf("fetchwr%0d_err", c), {15'd0, PCAlignErr}, 16'd0);
    end
    PCWrite   = 1'b0;
    IMemReady = 1'b1;
    IMemData  = 16'h0111;
    tick();
    IMemReady = 1'b0;
    check("fetchwr_done_ir", IR, 16'h0111);
    check("fetchwr_done_irvalid", {15'd0, IRValid}, 16'd1);
    check("fetchwr_done_pc", PC, 16'h0000);

    // Stall together with PCWrite in HOLD blocks the load.
    Stall      = 1'b1;
    PCWrite    = 1'b1;
    SelectedPC = 16'h0200;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall%0d_pc", c), PC, 16'h0000);
      check($sformatf("stall%0d_irvalid", c), {15'd0, IRValid}, 16'd1);
      check($sformatf("stall%0d_req", c), {15'd0, IMemReq}, 16'd0);
    end
    Stall = 1'b0;
    tick();
    PCWrite = 1'b0;
    check("unstall_pc", PC, 16'h0200);
    check("unstall_irvalid", {15'd0, IRValid}, 16'd0);
    check("unstall_req", {15'd0, IMemReq}, 16'd1);

    // Wait states: request and address held stable.
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("wait%0d_req", c), {15'd0, IMemReq}, 16'd1);
      check($sformatf("wait%0d_addr", c), IMemAddr, 16'h0200);
    end

    // Asynchronous reset mid-fetch, away from any clock edge.
    #2;
    Reset_n   = 1'b0;
    IMemReady = 1'b1;
    IMemData  = 16'hBEEF;
    #1;
    check("arst_req", {15'd0, IMemReq}, 16'd0);
    check("arst_pc", PC, 16'h0000);
    check("arst_irvalid", {15'd0, IRValid}, 16'd0);
    check("arst_ir", IR, 16'h0000);
    Stall = 1'b1;
    tick();
    check("arst_hold_ir", IR, 16'h0000);
    Reset_n = 1'b1;
    // Stall keeps the unit in IDLE after reset release.
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("idlestall%0d_req", c), {15'd0, IMemReq}, 16'd0);
      check($sformatf("idlestall%0d_irvalid", c), {15'd0, IRValid}, 16'd0);
    end
    Stall = 1'b0;
    tick();
    check("restart_req", {15'd0, IMemReq}, 16'd1);
    check("restart_addr", IMemAddr, 16'h0000);
    tick();
    check("restart_ir", IR, 16'hBEEF);
    check("restart_inc", PCincrement, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
